// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment glyph constants and types
package seg7_pkg;

  localparam int SEG_W = 7;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

  // Glyph table indexed by nibble value; same layout the display driver uses
  typedef logic [15:0][SEG_W-1:0] glyph_arr_t;

  localparam glyph_arr_t GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - active-high segment pattern to hex nibble decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pat,
  output logic             valid,
  output logic [3:0]       nibble
);

  // Match the pattern against every glyph; glyphs are unique so at most one hits
  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pat == GLYPHS[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - stable-pattern sampler and decoder for a multiplexed 7-seg bus (option: SEG7_READER_DP_EN)
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
`ifdef SEG7_READER_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dps,
`endif
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    out_valid,
  output logic [2:0]              out_idx,
  output logic [3:0]              out_nibble,
  output logic                    err_pulse,
  output logic                    err_sticky
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
  localparam logic [SEG_W-1:0] SEG_UNLIT = (ACTIVE_LOW != 0) ? '1 : '0;

`ifdef SEG7_READER_DP_EN
  localparam int IN_W = 1 + SEG_W + NUM_DIGITS;
  localparam logic [IN_W-1:0] IN_RST = {(ACTIVE_LOW != 0), SEG_UNLIT, {NUM_DIGITS{1'b0}}};
  wire [IN_W-1:0] in_w = {dp, seg, dig_sel};
`else
  localparam int IN_W = SEG_W + NUM_DIGITS;
  localparam logic [IN_W-1:0] IN_RST = {SEG_UNLIT, {NUM_DIGITS{1'b0}}};
  wire [IN_W-1:0] in_w = {seg, dig_sel};
`endif

  logic [IN_W-1:0]       in_q;
  logic [CNT_W-1:0]      cnt;
  logic                  armed;
  logic [NUM_DIGITS-1:0] q_sel;
  logic [SEG_W-1:0]      q_seg_norm;
  logic                  dec_valid;
  logic [3:0]            dec_nibble;
  logic [3:0]            sel_cnt;
  logic [2:0]            sel_idx;
  logic                  same;
  logic                  cap_point;

  assign q_sel      = in_q[NUM_DIGITS-1:0];
  assign q_seg_norm = (ACTIVE_LOW != 0) ? ~in_q[NUM_DIGITS +: SEG_W] : in_q[NUM_DIGITS +: SEG_W];
  assign same       = (in_w == in_q);
  // Capture point is reached once per stable period, whether or not the select is usable
  assign cap_point  = same && armed && (cnt == CNT_CAP);

`ifdef SEG7_READER_DP_EN
  logic q_dp_norm;
  assign q_dp_norm = (ACTIVE_LOW != 0) ? ~in_q[IN_W-1] : in_q[IN_W-1];
`endif

  seg7_decode u_decode (
    .pat    (q_seg_norm),
    .valid  (dec_valid),
    .nibble (dec_nibble)
  );

  // Count set select lines and remember the index of the (last) set one
  always_comb begin
    sel_cnt = 4'd0;
    sel_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (q_sel[i]) begin
        sel_cnt = sel_cnt + 4'd1;
        sel_idx = 3'(i);
      end
    end
  end

  // Sample the bus and track how long it has been unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= IN_RST;
      cnt   <= '0;
      armed <= 1'b1;
    end else begin
      in_q <= in_w;
      if (!same) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else if (cap_point) begin
        cnt   <= CNT_SAT;
        armed <= 1'b0;
      end else if (cnt < CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Register the decoded capture or flag an illegal glyph; a new error beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits     <= '0;
      out_valid  <= 1'b0;
      out_idx    <= 3'd0;
      out_nibble <= 4'd0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
`ifdef SEG7_READER_DP_EN
      dps        <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      err_pulse <= 1'b0;
      if (err_clr) begin
        err_sticky <= 1'b0;
      end
      if (cap_point && (sel_cnt == 4'd1)) begin
        if (dec_valid) begin
          out_valid  <= 1'b1;
          out_idx    <= sel_idx;
          out_nibble <= dec_nibble;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (q_sel[i]) begin
              digits[4*i +: 4] <= dec_nibble;
`ifdef SEG7_READER_DP_EN
              dps[i] <= q_dp_norm;
`endif
            end
          end
        end else begin
          err_pulse  <= 1'b1;
          err_sticky <= 1'b1;
        end
      end
    end
  end

endmodule
